// File: rtl/uart_rx_ctrl.sv
// Host-side drain controller for the UART receiver: acknowledges bytes into a local FIFO,
// clears sticky framing errors and counts error events. Optional byte tagging: UART_RX_CTRL_ERR_TAG_EN.
module uart_rx_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_valid,
  input  logic                     framing_err,
  input  logic                     overrun,
  output logic                     host_ready,
  output logic                     clear_framing_err,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         ferr_cnt,
  output logic [CNT_W-1:0]         ovr_cnt,
  input  logic                     cnt_clr
`ifdef UART_RX_CTRL_ERR_TAG_EN
  ,
  output logic                     out_frame_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_CTRL_ERR_TAG_EN
  localparam int WW = 9;
`else
  localparam int WW = 8;
`endif

  typedef enum logic {
    WAIT,
    HOLDOFF
  } state_t;

  state_t          state;
  logic [WW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            push;
  logic            pop;
  logic [WW-1:0]   push_word;
  logic [WW-1:0]   head;
  logic            ferr_q;
  logic            ovr_q;
  logic            ferr_rise;
  logic            ovr_rise;
  logic [1:0]      clr_age;
`ifdef UART_RX_CTRL_ERR_TAG_EN
  logic            pending_ferr;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign full       = (count == CW'(DEPTH));
  // No bypass: a full FIFO blocks the acknowledge even if a pop happens this cycle.
  assign host_ready = ~rst & (state == WAIT) & rx_data_valid & en & ~full;
  assign push       = host_ready;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign fifo_count = count;
  assign ferr_rise  = framing_err & ~ferr_q;
  assign ovr_rise   = overrun & ~ovr_q;
  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head[7:0] : '0;

`ifdef UART_RX_CTRL_ERR_TAG_EN
  assign push_word     = {pending_ferr | ferr_rise, rx_data};
  assign out_frame_err = out_valid & head[8];
`else
  assign push_word     = rx_data;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= WAIT;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      ferr_q            <= 1'b0;
      ovr_q             <= 1'b0;
      clr_age           <= '0;
      clear_framing_err <= 1'b0;
      ferr_cnt          <= '0;
      ovr_cnt           <= '0;
`ifdef UART_RX_CTRL_ERR_TAG_EN
      pending_ferr      <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT:    if (host_ready) state <= HOLDOFF;
        HOLDOFF: state <= WAIT;
        default: state <= WAIT;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      ferr_q <= framing_err;
      ovr_q  <= overrun;

      // clr_age runs 1,2,3 after each clear pulse; at 3 a still-high flag earns another pulse.
      clear_framing_err <= ferr_rise | (framing_err & (clr_age == 2'd3));
      if (clear_framing_err)      clr_age <= 2'd1;
      else if (clr_age != 2'd0)   clr_age <= clr_age + 2'd1;

      if (cnt_clr)        ferr_cnt <= '0;
      else if (ferr_rise) ferr_cnt <= sat_inc(ferr_cnt);
      if (cnt_clr)        ovr_cnt  <= '0;
      else if (ovr_rise)  ovr_cnt  <= sat_inc(ovr_cnt);

`ifdef UART_RX_CTRL_ERR_TAG_EN
      if (push)           pending_ferr <= 1'b0;
      else if (ferr_rise) pending_ferr <= 1'b1;
`endif
    end
  end

endmodule
